ann_pad_bridge: RTL and testbench

Parametrised GPIO-pad front-end for the ANN core, replacing fixed pin slicing with a real transport layer. Input words arrive on a pad bus, qualified by a host strobe under a 4-phase handshake. They are buffered in a FIFO and handed to the core over valid/ready. Core results are serialised onto a narrow output pad bus with a valid pin; the block also drives the pad output-enable bits.

---
 rtl/ann_pad_bridge.sv | 235 +++++++++++++++++++++++
 tb/tb_ann_pad_bridge.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ann_pad_bridge.sv
// Purpose : GPIO-pad transport for the ANN core. Host words in over a 4-phase
//           strobe/ack handshake into a FWFT FIFO; core results out as
//           MSB-first OUT_W-wide beats on the output pads.
// Latency : strobe rise -> push SYNC_STAGES+1 cycles, push -> in_valid_o 1,
//           ack one cycle after push; result accept -> first beat 1 cycle.
// Backpr. : a full FIFO withholds pad_ack_o until a slot frees; res_ready_o
//           stays low while a result is being serialised.
//
// Ports:
//   wb_clk_i, wb_rst_ni     clock, async active-low reset
//   pad_data_i, pad_stb_i   host data pins and asynchronous strobe
//   pad_ack_o               4-phase acknowledge to host
//   in_data_o/in_valid_o/in_ready_i   FIFO head to core (valid/ready)
//   fifo_count_o            words currently buffered
//   res_data_i/res_valid_i/res_ready_o   core result (valid/ready)
//   pad_out_o, pad_out_vld_o   serialised beat pins
//   pad_oeb_o               active-low enables for {ack, out_vld, out}
module ann_pad_bridge #(
  parameter int IN_W        = 24,
  parameter int DEPTH       = 4,
  parameter int RES_W       = 16,
  parameter int OUT_W       = 4,
  parameter int OUT_HOLD    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic [IN_W-1:0]          pad_data_i,
  input  logic                     pad_stb_i,
  output logic                     pad_ack_o,
  output logic [IN_W-1:0]          in_data_o,
  output logic                     in_valid_o,
  input  logic                     in_ready_i,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  input  logic [RES_W-1:0]         res_data_i,
  input  logic                     res_valid_i,
  output logic                     res_ready_o,
  output logic [OUT_W-1:0]         pad_out_o,
  output logic                     pad_out_vld_o,
  output logic [OUT_W+1:0]         pad_oeb_o
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int BEATS = RES_W / OUT_W;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int HW    = $clog2(OUT_HOLD + 1);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_WAIT  = 2'd1;
  localparam logic [1:0] C_ACK   = 2'd2;

  localparam logic [0:0] O_IDLE  = 1'b0;
  localparam logic [0:0] O_SHIFT = 1'b1;

  // ------------------------------------------------------------------
  // Pads come alive on the first clock after reset release.
  // ------------------------------------------------------------------
  logic live_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) live_q <= 1'b0;
    else            live_q <= 1'b1;
  end

  assign pad_oeb_o = live_q ? '0 : '1;

  // ------------------------------------------------------------------
  // Strobe synchroniser. The chain and stb_prev reset high so a strobe
  // held across reset release is not mistaken for a fresh rising edge;
  // it must be seen low before the next capture.
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] stb_sync;
  logic                   stb_s;
  logic                   stb_prev;
  logic                   stb_rise;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      stb_sync <= '1;
      stb_prev <= 1'b1;
    end else begin
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], pad_stb_i};
      stb_prev <= stb_s;
    end
  end

  assign stb_s    = stb_sync[SYNC_STAGES-1];
  assign stb_rise = stb_s & ~stb_prev;

  // ------------------------------------------------------------------
  // FIFO state (declared early; the capture FSM reads fifo_full).
  // ------------------------------------------------------------------
  logic [IN_W-1:0] mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            fifo_full;
  logic            push, pop;
  logic [IN_W-1:0] push_data;

  // Registered count only: a pop in the same cycle does not free the slot
  // for a push until the following cycle.
  assign fifo_full = (count >= CW'(DEPTH));

  // ------------------------------------------------------------------
  // Capture FSM
  // ------------------------------------------------------------------
  logic [1:0]      cap_state, cap_next;
  logic [IN_W-1:0] hold_q;
  logic            ack_q;

  always_comb begin
    cap_next  = cap_state;
    push      = 1'b0;
    push_data = hold_q;
    case (cap_state)
      C_IDLE: begin
        if (stb_rise) begin
          // Pad data is stable while the strobe is high, so push it directly.
          push_data = pad_data_i;
          if (!fifo_full) begin
            push     = 1'b1;
            cap_next = C_ACK;
          end else begin
            cap_next = C_WAIT;
          end
        end
      end
      C_WAIT: begin
        if (!fifo_full) begin
          push     = 1'b1;
          cap_next = C_ACK;
        end
      end
      C_ACK: begin
        if (!stb_s) cap_next = C_IDLE;
      end
      default: cap_next = C_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cap_state <= C_IDLE;
      hold_q    <= '0;
      ack_q     <= 1'b0;
    end else begin
      cap_state <= cap_next;
      if (cap_state == C_IDLE && stb_rise) hold_q <= pad_data_i;
      // Ack follows the push by a cycle and drops together with the
      // return to IDLE once the synchronised strobe is low.
      ack_q <= (cap_state == C_ACK) && stb_s;
    end
  end

  assign pad_ack_o = ack_q;

  // ------------------------------------------------------------------
  // FIFO: first-word fall-through, pointers wrap modulo DEPTH (power of 2).
  // ------------------------------------------------------------------
  assign in_valid_o   = (count != '0);
  assign pop          = in_valid_o & in_ready_i;
  assign in_data_o    = in_valid_o ? mem[rptr] : '0;
  assign fifo_count_o = count;

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wptr] <= push_data;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Result serialiser
  // ------------------------------------------------------------------
  logic [0:0]       o_state;
  logic [RES_W-1:0] shreg;
  logic [BW-1:0]    beat_cnt;
  logic [HW-1:0]    hold_cnt;
  logic             accept;

  assign res_ready_o = live_q && (o_state == O_IDLE);
  assign accept      = res_valid_i & res_ready_o;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      o_state  <= O_IDLE;
      shreg    <= '0;
      beat_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      case (o_state)
        O_IDLE: begin
          if (accept) begin
            shreg    <= res_data_i;
            beat_cnt <= BW'(BEATS);
            hold_cnt <= HW'(OUT_HOLD);
            o_state  <= O_SHIFT;
          end
        end
        O_SHIFT: begin
          if (hold_cnt == HW'(1)) begin
            if (beat_cnt == BW'(1)) begin
              o_state <= O_IDLE;
            end else begin
              shreg    <= shreg << OUT_W;
              beat_cnt <= beat_cnt - BW'(1);
              hold_cnt <= HW'(OUT_HOLD);
            end
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: o_state <= O_IDLE;
      endcase
    end
  end

  assign pad_out_vld_o = (o_state == O_SHIFT);
  assign pad_out_o     = pad_out_vld_o ? shreg[RES_W-1 -: OUT_W] : '0;

endmodule

// File: tb/tb_ann_pad_bridge.sv
module tb_ann_pad_bridge;

  localparam int IN_W        = 24;
  localparam int DEPTH       = 4;
  localparam int RES_W       = 16;
  localparam int OUT_W       = 4;
  localparam int OUT_HOLD    = 2;
  localparam int SYNC_STAGES = 2;

  logic              wb_clk_i   = 1'b0;
  logic              wb_rst_ni  = 1'b0;
  logic [IN_W-1:0]   pad_data_i = '0;
  logic              pad_stb_i  = 1'b1;
  logic              pad_ack_o;
  logic [IN_W-1:0]   in_data_o;
  logic              in_valid_o;
  logic              in_ready_i = 1'b0;
  logic [2:0]        fifo_count_o;
  logic [RES_W-1:0]  res_data_i = '0;
  logic              res_valid_i = 1'b0;
  logic              res_ready_o;
  logic [OUT_W-1:0]  pad_out_o;
  logic              pad_out_vld_o;
  logic [OUT_W+1:0]  pad_oeb_o;

  int tests_run    = 0;
  int tests_failed = 0;

  ann_pad_bridge #(
    .IN_W(IN_W), .DEPTH(DEPTH), .RES_W(RES_W), .OUT_W(OUT_W),
    .OUT_HOLD(OUT_HOLD), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_ni     (wb_rst_ni),
    .pad_data_i    (pad_data_i),
    .pad_stb_i     (pad_stb_i),
    .pad_ack_o     (pad_ack_o),
    .in_data_o     (in_data_o),
    .in_valid_o    (in_valid_o),
    .in_ready_i    (in_ready_i),
    .fifo_count_o  (fifo_count_o),
    .res_data_i    (res_data_i),
    .res_valid_i   (res_valid_i),
    .res_ready_o   (res_ready_o),
    .pad_out_o     (pad_out_o),
    .pad_out_vld_o (pad_out_vld_o),
    .pad_oeb_o     (pad_oeb_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  // Full 4-phase transfer; leaves the strobe high if no ack arrives.
  task automatic send_word(input logic [IN_W-1:0] d, output bit acked);
    pad_data_i = d;
    pad_stb_i  = 1'b1;
    acked      = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (pad_ack_o) begin acked = 1'b1; break; end
    end
    if (acked) begin
      pad_stb_i = 1'b0;
      for (int i = 0; i < 12; i++) begin
        step(1);
        if (!pad_ack_o) break;
      end
    end
  endtask

  task automatic test_reset;
    wb_rst_ni = 1'b0;
    pad_stb_i = 1'b1;
    step(2);
    tests_run++; if (pad_ack_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %0b want 0", pad_ack_o); end
    tests_run++; if (in_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_in_valid: got %0b want 0", in_valid_o); end
    tests_run++; if (in_data_o !== 24'h0) begin tests_failed++; $display("FAIL reset_in_data: got %h want 0", in_data_o); end
    tests_run++; if (fifo_count_o !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", fifo_count_o); end
    tests_run++; if (res_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_res_ready: got %0b want 0", res_ready_o); end
    tests_run++; if (pad_out_o !== 4'h0 || pad_out_vld_o !== 1'b0) begin tests_failed++; $display("FAIL reset_pad_out: got %h/%0b want 0/0", pad_out_o, pad_out_vld_o); end
    tests_run++; if (pad_oeb_o !== 6'b111111) begin tests_failed++; $display("FAIL reset_oeb: got %b want 111111", pad_oeb_o); end
    wb_rst_ni = 1'b1;
    step(1);
    tests_run++; if (pad_oeb_o !== 6'b000000) begin tests_failed++; $display("FAIL release_oeb: got %b want 000000", pad_oeb_o); end
    tests_run++; if (res_ready_o !== 1'b1) begin tests_failed++; $display("FAIL release_res_ready: got %0b want 1", res_ready_o); end
    step(8);
    tests_run++; if (pad_ack_o !== 1'b0 || fifo_count_o !== 3'd0) begin tests_failed++; $display("FAIL held_strobe_no_capture: ack %0b count %0d want 0/0", pad_ack_o, fifo_count_o); end
    pad_stb_i = 1'b0;
    step(4);
  endtask

  task automatic test_single_word;
    int n;
    pad_data_i = 24'hA5C3F0;
    pad_stb_i  = 1'b1;
    step(SYNC_STAGES + 1);
    tests_run++; if (in_valid_o !== 1'b1 || pad_ack_o !== 1'b0) begin tests_failed++; $display("FAIL single_push_timing: valid %0b ack %0b want 1/0", in_valid_o, pad_ack_o); end
    step(1);
    tests_run++; if (pad_ack_o !== 1'b1) begin tests_failed++; $display("FAIL single_ack_rise: got %0b want 1", pad_ack_o); end
    tests_run++; if (in_data_o !== 24'hA5C3F0) begin tests_failed++; $display("FAIL single_data: got %h want a5c3f0", in_data_o); end
    tests_run++; if (fifo_count_o !== 3'd1) begin tests_failed++; $display("FAIL single_count: got %0d want 1", fifo_count_o); end
    pad_stb_i = 1'b0;
    n = 0;
    while (pad_ack_o && n < SYNC_STAGES + 1) begin step(1); n++; end
    tests_run++; if (pad_ack_o !== 1'b0) begin tests_failed++; $display("FAIL single_ack_fall: got %0b want 0 after %0d cycles", pad_ack_o, n); end
    in_ready_i = 1'b1;
    step(1);
    in_ready_i = 1'b0;
    tests_run++; if (fifo_count_o !== 3'd0 || in_valid_o !== 1'b0) begin tests_failed++; $display("FAIL single_pop: count %0d valid %0b want 0/0", fifo_count_o, in_valid_o); end
  endtask

  task automatic test_fill;
    bit a;
    int n_ack;
    logic [IN_W-1:0] exp_d;
    in_ready_i = 1'b0;
    n_ack = 0;
    for (int w = 1; w <= 4; w++) begin
      send_word(IN_W'(w), a);
      if (a) n_ack++;
    end
    tests_run++; if (n_ack != 4) begin tests_failed++; $display("FAIL fill_acks: got %0d want 4", n_ack); end
    tests_run++; if (fifo_count_o !== 3'd4 || in_data_o !== 24'd1) begin tests_failed++; $display("FAIL fill_full: count %0d head %h want 4/1", fifo_count_o, in_data_o); end
    pad_data_i = 24'd5;
    pad_stb_i  = 1'b1;
    step(10);
    tests_run++; if (pad_ack_o !== 1'b0 || fifo_count_o !== 3'd4) begin tests_failed++; $display("FAIL fill_withheld: ack %0b count %0d want 0/4", pad_ack_o, fifo_count_o); end
    in_ready_i = 1'b1;
    step(1);
    in_ready_i = 1'b0;
    tests_run++; if (fifo_count_o !== 3'd3 || in_data_o !== 24'd2) begin tests_failed++; $display("FAIL fill_pop: count %0d head %h want 3/2", fifo_count_o, in_data_o); end
    step(1);
    tests_run++; if (fifo_count_o !== 3'd4 || pad_ack_o !== 1'b0) begin tests_failed++; $display("FAIL fill_deferred_push: count %0d ack %0b want 4/0", fifo_count_o, pad_ack_o); end
    step(1);
    tests_run++; if (pad_ack_o !== 1'b1) begin tests_failed++; $display("FAIL fill_late_ack: got %0b want 1", pad_ack_o); end
    pad_stb_i = 1'b0;
    step(4);
    in_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = IN_W'(k + 2);
      tests_run++; if (in_valid_o !== 1'b1 || in_data_o !== exp_d) begin tests_failed++; $display("FAIL fill_drain_%0d: valid %0b data %h want 1/%h", k, in_valid_o, in_data_o, exp_d); end
      step(1);
    end
    in_ready_i = 1'b0;
    tests_run++; if (fifo_count_o !== 3'd0) begin tests_failed++; $display("FAIL fill_empty: got %0d want 0", fifo_count_o); end
  endtask

  task automatic test_push_pop;
    bit a;
    send_word(24'h000011, a);
    send_word(24'h000022, a);
    tests_run++; if (fifo_count_o !== 3'd2) begin tests_failed++; $display("FAIL pp_pre_count: got %0d want 2", fifo_count_o); end
    pad_data_i = 24'h000033;
    pad_stb_i  = 1'b1;
    step(SYNC_STAGES);
    in_ready_i = 1'b1;
    step(1);
    in_ready_i = 1'b0;
    tests_run++; if (fifo_count_o !== 3'd2 || in_data_o !== 24'h000022) begin tests_failed++; $display("FAIL pp_same_cycle: count %0d head %h want 2/000022", fifo_count_o, in_data_o); end
    step(1);
    pad_stb_i = 1'b0;
    step(4);
    in_ready_i = 1'b1;
    step(1);
    tests_run++; if (in_data_o !== 24'h000033) begin tests_failed++; $display("FAIL pp_order: got %h want 000033", in_data_o); end
    step(1);
    in_ready_i = 1'b0;
    tests_run++; if (fifo_count_o !== 3'd0) begin tests_failed++; $display("FAIL pp_empty: got %0d want 0", fifo_count_o); end
  endtask

  task automatic test_serialise;
    logic [3:0] exp_seq [8];
    exp_seq = '{4'h1, 4'h1, 4'hE, 4'hE, 4'h7, 4'h7, 4'hB, 4'hB};
    tests_run++; if (res_ready_o !== 1'b1) begin tests_failed++; $display("FAIL ser_idle_ready: got %0b want 1", res_ready_o); end
    res_data_i  = 16'h1E7B;
    res_valid_i = 1'b1;
    step(1);
    res_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin res_data_i = 16'h5AC3; res_valid_i = 1'b1; end
      tests_run++; if (pad_out_vld_o !== 1'b1 || res_ready_o !== 1'b0 || pad_out_o !== exp_seq[i]) begin tests_failed++; $display("FAIL ser_beat_%0d: out %h vld %0b rdy %0b want %h/1/0", i, pad_out_o, pad_out_vld_o, res_ready_o, exp_seq[i]); end
      step(1);
    end
    tests_run++; if (pad_out_vld_o !== 1'b0 || pad_out_o !== 4'h0 || res_ready_o !== 1'b1) begin tests_failed++; $display("FAIL ser_gap: out %h vld %0b rdy %0b want 0/0/1", pad_out_o, pad_out_vld_o, res_ready_o); end
    step(1);
    res_valid_i = 1'b0;
    tests_run++; if (pad_out_vld_o !== 1'b1 || pad_out_o !== 4'h5) begin tests_failed++; $display("FAIL ser_second_accept: out %h vld %0b want 5/1", pad_out_o, pad_out_vld_o); end
    step(8);
    tests_run++; if (pad_out_vld_o !== 1'b0 || res_ready_o !== 1'b1) begin tests_failed++; $display("FAIL ser_second_done: vld %0b rdy %0b want 0/1", pad_out_vld_o, res_ready_o); end
  endtask

  task automatic test_reset_mid_serialise;
    bit a;
    bit stray;
    send_word(24'h777777, a);
    tests_run++; if (fifo_count_o !== 3'd1) begin tests_failed++; $display("FAIL rms_pre_count: got %0d want 1", fifo_count_o); end
    res_data_i  = 16'h9F36;
    res_valid_i = 1'b1;
    step(1);
    res_valid_i = 1'b0;
    step(2);
    tests_run++; if (pad_out_o !== 4'hF || pad_out_vld_o !== 1'b1) begin tests_failed++; $display("FAIL rms_beat2: out %h vld %0b want f/1", pad_out_o, pad_out_vld_o); end
    wb_rst_ni = 1'b0;
    #1;
    tests_run++; if (pad_out_vld_o !== 1'b0 || pad_out_o !== 4'h0 || pad_oeb_o !== 6'b111111) begin tests_failed++; $display("FAIL rms_immediate: out %h vld %0b oeb %b want 0/0/111111", pad_out_o, pad_out_vld_o, pad_oeb_o); end
    step(2);
    wb_rst_ni = 1'b1;
    step(1);
    tests_run++; if (fifo_count_o !== 3'd0 || in_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rms_fifo_empty: count %0d valid %0b want 0/0", fifo_count_o, in_valid_o); end
    stray = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (pad_out_vld_o !== 1'b0) stray = 1'b1;
      step(1);
    end
    tests_run++; if (stray !== 1'b0 || pad_ack_o !== 1'b0) begin tests_failed++; $display("FAIL rms_no_residual: stray %0b ack %0b want 0/0", stray, pad_ack_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_fill();
    test_push_pop();
    test_serialise();
    test_reset_mid_serialise();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
